// File: rtl/disp_hex_mux_n.sv
// Multiplexed N-digit seven-segment driver: prescaled digit scan, double-buffered
// display data swapped only at frame wrap, and a dark lead-in at the start of each slot.
module disp_hex_mux_n #(
    parameter int unsigned DVSR           = 120000,
    parameter int unsigned DIGITS         = 6,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter bit          ACTIVE_LOW_AN  = 1'b1,
    parameter bit          ACTIVE_LOW_SEG = 1'b1,
    localparam int unsigned PW            = $clog2(DVSR),
    localparam int unsigned DW            = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  CLK_12_MHZ,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            sseg,
    output logic [DW-1:0]         digit_idx,
    output logic                  frame_tick
);

    localparam logic [DIGITS-1:0] AnOff  = {DIGITS{ACTIVE_LOW_AN}};
    localparam logic [7:0]        SegOff = {8{ACTIVE_LOW_SEG}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [PW-1:0]         p_q, p_d;
    logic [DW-1:0]         d_q, d_d;
    logic                  pending_q;
    logic [4*DIGITS-1:0]   hex_sh_q, hex_act_q;
    logic [DIGITS-1:0]     dp_sh_q, dp_act_q;
    logic [DIGITS-1:0]     blank_sh_q, blank_act_q;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [7:0]            sseg_q, sseg_d;
    logic                  frame_tick_q;

    logic                  slot_end;
    logic                  frame_wrap;
    logic                  past_blank;
    logic                  lit;
    logic [3:0]            cur_hex;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [DIGITS-1:0]     an_onehot;

    // Scan only advances while enabled, so a wrap can never fire with en low.
    assign slot_end   = en && (p_q == PW'(DVSR - 1));
    assign frame_wrap = slot_end && (d_q == DW'(DIGITS - 1));

    always_comb begin
        p_d = p_q;
        d_d = d_q;
        if (en) begin
            if (slot_end) begin
                p_d = '0;
                d_d = (d_q == DW'(DIGITS - 1)) ? '0 : d_q + DW'(1);
            end else begin
                p_d = p_q + PW'(1);
            end
        end
    end

    always_comb begin
        cur_hex   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_onehot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (d_q == DW'(k)) begin
                cur_hex      = hex_act_q[4*k +: 4];
                cur_dp       = dp_act_q[k];
                cur_blank    = blank_act_q[k];
                an_onehot[k] = 1'b1;
            end
        end
    end

    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign past_blank = 1'b1;
    end else begin : g_blank
        assign past_blank = (p_q >= PW'(BLANK_CYCLES));
    end

    assign lit = en && past_blank && !cur_blank;

    always_comb begin
        an_d   = (lit ? an_onehot : '0) ^ AnOff;
        sseg_d = (lit ? {cur_dp, hex_to_seg(cur_hex)} : 8'h00) ^ SegOff;
    end

    always_ff @(posedge CLK_12_MHZ) begin
        if (RST) begin
            p_q          <= '0;
            d_q          <= '0;
            an_q         <= AnOff;
            sseg_q       <= SegOff;
            frame_tick_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            d_q          <= d_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_wrap;
        end
    end

    // A load coinciding with the wrap bypasses the shadow so it is not a frame late.
    always_ff @(posedge CLK_12_MHZ) begin
        if (RST) begin
            pending_q   <= 1'b0;
            hex_sh_q    <= '0;
            dp_sh_q     <= '0;
            blank_sh_q  <= '0;
            hex_act_q   <= '0;
            dp_act_q    <= '0;
            blank_act_q <= '0;
        end else if (load && frame_wrap) begin
            pending_q   <= 1'b0;
            hex_act_q   <= hex_in;
            dp_act_q    <= dp_in;
            blank_act_q <= blank_in;
        end else if (load) begin
            pending_q   <= 1'b1;
            hex_sh_q    <= hex_in;
            dp_sh_q     <= dp_in;
            blank_sh_q  <= blank_in;
        end else if (frame_wrap && pending_q) begin
            pending_q   <= 1'b0;
            hex_act_q   <= hex_sh_q;
            dp_act_q    <= dp_sh_q;
            blank_act_q <= blank_sh_q;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign digit_idx  = d_q;
    assign frame_tick = frame_tick_q;

    a_one_anode: assert property (@(posedge CLK_12_MHZ) disable iff (RST)
        $onehot0(an_q ^ AnOff));

endmodule

// File: tb/tb_disp_hex_mux_n.sv
// Scoreboard bench for disp_hex_mux_n: a 4-digit active-low instance and an 8-digit
// active-high instance, expected per-cycle outputs queued by cycle number.
module tb_disp_hex_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        en_a, load_a;
    logic [15:0] hex_a;
    logic [3:0]  dp_a, blank_a, an_a;
    logic [7:0]  sseg_a;
    logic [1:0]  idx_a;
    logic        ft_a;

    logic        en_b, load_b;
    logic [31:0] hex_b;
    logic [7:0]  dp_b, blank_b, an_b, sseg_b;
    logic [2:0]  idx_b;
    logic        ft_b;

    disp_hex_mux_n #(
        .DVSR(4), .DIGITS(4), .BLANK_CYCLES(1), .ACTIVE_LOW_AN(1'b1), .ACTIVE_LOW_SEG(1'b1)
    ) u_dut_a (
        .CLK_12_MHZ(clk), .RST(rst), .en(en_a), .load(load_a), .hex_in(hex_a),
        .dp_in(dp_a), .blank_in(blank_a), .an(an_a), .sseg(sseg_a),
        .digit_idx(idx_a), .frame_tick(ft_a)
    );

    disp_hex_mux_n #(
        .DVSR(3), .DIGITS(8), .BLANK_CYCLES(0), .ACTIVE_LOW_AN(1'b0), .ACTIVE_LOW_SEG(1'b0)
    ) u_dut_b (
        .CLK_12_MHZ(clk), .RST(rst), .en(en_b), .load(load_b), .hex_in(hex_b),
        .dp_in(dp_b), .blank_in(blank_b), .an(an_b), .sseg(sseg_b),
        .digit_idx(idx_b), .frame_tick(ft_b)
    );

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [7:0] sseg;
        logic       ft;
        logic [3:0] idx;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input bit to_b, input int c, input logic [7:0] an,
                                 input logic [7:0] sseg, input logic ft, input int idx);
        exp_t e;
        e.cyc  = c;
        e.an   = an;
        e.sseg = sseg;
        e.ft   = ft;
        e.idx  = 4'(idx);
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
    endfunction

    // One 4-cycle slot of instance A: dark lead-in, then three lit cycles.
    function automatic void slot_a(input int c0, input int dig, input logic [7:0] seg,
                                   input bit dark, input bit last);
        logic [3:0] on;
        on = 4'b0001 << dig;
        on = ~on;
        push(1'b0, c0, 8'h0F, 8'hFF, 1'b0, dig);
        for (int j = 1; j < 4; j++) begin
            push(1'b0, c0 + j, dark ? 8'h0F : {4'h0, on}, dark ? 8'hFF : seg,
                 last && (j == 3), (j == 3) ? (dig + 1) % 4 : dig);
        end
    endfunction

    function automatic void frame_a(input int c0, input logic [7:0] s0, input logic [7:0] s1,
                                    input logic [7:0] s2, input logic [7:0] s3,
                                    input logic [3:0] dark);
        slot_a(c0,      0, s0, dark[0], 1'b0);
        slot_a(c0 + 4,  1, s1, dark[1], 1'b0);
        slot_a(c0 + 8,  2, s2, dark[2], 1'b0);
        slot_a(c0 + 12, 3, s3, dark[3], 1'b1);
    endfunction

    function automatic void frame_b(input int c0, input logic [63:0] segs);
        for (int s = 0; s < 8; s++) begin
            for (int j = 0; j < 3; j++) begin
                push(1'b1, c0 + 3*s + j, 8'(1) << s, segs[8*s +: 8],
                     (s == 7) && (j == 2), (j == 2) ? (s + 1) % 8 : s);
            end
        end
    endfunction

    function automatic void check(input string name, input exp_t e, input logic [7:0] an,
                                  input logic [7:0] sseg, input logic ft, input logic [3:0] idx);
        n_tests++;
        if (e.cyc != cyc || an !== e.an || sseg !== e.sseg || ft !== e.ft || idx !== e.idx) begin
            n_fail++;
            $display("FAIL %s cyc=%0d (exp for %0d): got an=%h sseg=%h ft=%b idx=%0d, want an=%h sseg=%h ft=%b idx=%0d",
                     name, cyc, e.cyc, an, sseg, ft, idx, e.an, e.sseg, e.ft, e.idx);
        end
    endfunction

    always @(negedge clk) begin
        while (qa.size() != 0 && qa[0].cyc <= cyc) begin
            ea = qa.pop_front();
            check("dutA", ea, {4'h0, an_a}, sseg_a, ft_a, {2'b00, idx_a});
        end
        while (qb.size() != 0 && qb[0].cyc <= cyc) begin
            eb = qb.pop_front();
            check("dutB", eb, an_b, sseg_b, ft_b, {1'b0, idx_b});
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b1; load_a = 1'b1; hex_a = 16'hFFFF; dp_a = '0; blank_a = '0;
        en_b = 1'b1; load_b = 1'b1; hex_b = '1;       dp_b = '0; blank_b = '0;
        for (int c = 1; c <= 3; c++) begin
            push(1'b0, c, 8'h0F, 8'hFF, 1'b0, 0);
            push(1'b1, c, 8'h00, 8'h00, 1'b0, 0);
        end
        frame_a(4, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000);
        frame_b(4, 64'h3F3F3F3F3F3F3F3F);

        goto(3);
        rst = 1'b0; load_a = 1'b0; load_b = 1'b0; hex_a = '0; hex_b = '0;

        goto(4);
        load_a = 1'b1; hex_a = 16'h3210; dp_a = 4'b0100;
        load_b = 1'b1; hex_b = 32'h76543210;
        frame_a(20, 8'hC0, 8'hF9, 8'h24, 8'hB0, 4'b0000);
        frame_b(28, 64'h077D6D664F5B063F);

        goto(5);
        load_a = 1'b0; hex_a = 16'h5555;
        load_b = 1'b0; hex_b = 32'h55555555;
        frame_a(36, 8'hC0, 8'hF9, 8'h24, 8'hB0, 4'b0000);
        frame_b(52, 64'h077D6D664F5B063F);

        // Load mid-frame while digit 1 is lit: takes effect only at the next frame.
        goto(41);
        load_a = 1'b1; hex_a = 16'hFFFF; dp_a = 4'b0000;
        goto(42);
        load_a = 1'b0; hex_a = 16'h0000;
        frame_a(52, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 4'b0000);

        // Load in the wrap cycle itself.
        goto(66);
        load_a = 1'b1; hex_a = 16'hAAAA;
        frame_a(68, 8'h88, 8'h88, 8'h88, 8'h88, 4'b0000);
        goto(67);
        load_a = 1'b0; hex_a = 16'h1234;
        slot_a(84, 0, 8'h88, 1'b0, 1'b0);
        slot_a(88, 1, 8'h88, 1'b0, 1'b0);
        push(1'b0, 92, 8'h0F, 8'hFF, 1'b0, 2);
        push(1'b0, 93, 8'h0B, 8'h88, 1'b0, 2);

        // Pause with p=2, d=2 for ten cycles.
        goto(93);
        en_a = 1'b0;
        for (int c = 94; c <= 103; c++) push(1'b0, c, 8'h0F, 8'hFF, 1'b0, 2);

        goto(103);
        en_a = 1'b1;
        push(1'b0, 104, 8'h0B, 8'h88, 1'b0, 2);
        push(1'b0, 105, 8'h0B, 8'h88, 1'b0, 3);
        slot_a(106, 3, 8'h88, 1'b0, 1'b1);
        frame_a(110, 8'h88, 8'h88, 8'h88, 8'h88, 4'b0010);

        goto(104);
        load_a = 1'b1; hex_a = 16'hAAAA; blank_a = 4'b0010;
        goto(105);
        load_a = 1'b0; blank_a = 4'b0000; hex_a = 16'h0000;

        goto(130);
        n_tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d/%0d expectations never compared, required 0/0",
                     qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
